// File: rtl/i2c_fsm_watchdog.sv
// Multi-channel FSM stall / timeout watchdog for the I2C controller.
// Per-channel OFF/TRACK/ALARM trackers plus a shared first-alarm record and timestamp.

module i2c_fsm_watchdog_ch #(
  parameter int STATE_W    = 4,
  parameter int CNT_W      = 16,
  parameter int IDLE_STATE = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [STATE_W-1:0] state_i,
  input  logic               evt_i,
  input  logic [CNT_W-1:0]   thresh_i,
  input  logic               idle_exempt_i,
  input  logic               clr_i,
  output logic               alarm_o,
  output logic [1:0]         cause_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               enter_o
);
  typedef enum logic [1:0] {ST_OFF, ST_TRACK, ST_ALARM} ch_st_e;

  ch_st_e             st, st_n;
  logic [STATE_W-1:0] last_q, last_n;
  logic               prime, prime_n;
  logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
  logic [1:0]         cause, cause_n;
  logic               match, exempt, hit;

  assign match   = (state_i == last_q);
  assign exempt  = idle_exempt_i && (state_i == STATE_W'(IDLE_STATE));
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
  // exact equality: a threshold lowered below a running count stays silent until restart
  assign hit     = prime && match && !exempt && (thresh_i != '0) && (cnt_inc == thresh_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st     <= ST_OFF;
      last_q <= '0;
      prime  <= 1'b0;
      cnt    <= '0;
      cause  <= '0;
    end else begin
      st     <= st_n;
      last_q <= last_n;
      prime  <= prime_n;
      cnt    <= cnt_n;
      cause  <= cause_n;
    end
  end

  always_comb begin
    st_n    = st;
    last_n  = last_q;
    prime_n = prime;
    cnt_n   = cnt;
    cause_n = cause;
    enter_o = 1'b0;
    if (!en_i) begin
      st_n    = ST_OFF;
      prime_n = 1'b0;
      cnt_n   = '0;
      cause_n = '0;
    end else begin
      case (st)
        ST_OFF: st_n = ST_TRACK;
        ST_TRACK: begin
          last_n = state_i;
          if (!prime) begin
            prime_n = 1'b1;
            cnt_n   = '0;
          end else if (!match || exempt) begin
            cnt_n = '0;
          end else begin
            cnt_n = cnt_inc;
          end
          if (hit || evt_i) begin
            st_n    = ST_ALARM;
            cause_n = {evt_i, hit};
            enter_o = 1'b1;
          end
        end
        ST_ALARM: begin
          last_n = state_i;
          if (clr_i) begin
            // an event racing the clear keeps the alarm, reporting only the event
            if (evt_i) begin
              cause_n = 2'b10;
            end else begin
              st_n    = ST_TRACK;
              prime_n = 1'b0;
              cnt_n   = '0;
              cause_n = '0;
            end
          end else begin
            cause_n[1] = cause[1] | evt_i;
          end
        end
        default: st_n = ST_OFF;
      endcase
    end
  end

  assign alarm_o = (st == ST_ALARM);
  assign cause_o = cause;
  assign cnt_o   = cnt;
endmodule

module i2c_fsm_watchdog #(
  parameter int NUM_CH     = 2,
  parameter int STATE_W    = 4,
  parameter int CNT_W      = 16,
  parameter int IDLE_STATE = 0,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_CH-1:0]         en_i,
  input  logic [NUM_CH*STATE_W-1:0] state_i,
  input  logic [NUM_CH-1:0]         evt_i,
  input  logic [CNT_W-1:0]          thresh_i,
  input  logic                      idle_exempt_i,
  input  logic [NUM_CH-1:0]         clr_i,
  input  logic                      first_clr_i,
  output logic [NUM_CH-1:0]         alarm_o,
  output logic [2*NUM_CH-1:0]       cause_o,
  output logic [NUM_CH*CNT_W-1:0]   stall_cnt_o,
  output logic                      irq_o,
  output logic                      first_valid_o,
  output logic [CH_W-1:0]           first_ch_o,
  output logic [CNT_W-1:0]          first_ts_o
);
  logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  logic [NUM_CH-1:0][1:0]       cause;
  logic [NUM_CH-1:0]            enter;
  logic [CNT_W-1:0]             ts;
  logic [CH_W-1:0]              first_idx;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    i2c_fsm_watchdog_ch #(
      .STATE_W(STATE_W), .CNT_W(CNT_W), .IDLE_STATE(IDLE_STATE)
    ) u_ch (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .en_i         (en_i[c]),
      .state_i      (state_i[c*STATE_W +: STATE_W]),
      .evt_i        (evt_i[c]),
      .thresh_i     (thresh_i),
      .idle_exempt_i(idle_exempt_i),
      .clr_i        (clr_i[c]),
      .alarm_o      (alarm_o[c]),
      .cause_o      (cause[c]),
      .cnt_o        (cnt[c]),
      .enter_o      (enter[c])
    );
  end

  assign cause_o     = cause;
  assign stall_cnt_o = cnt;
  assign irq_o       = |alarm_o;

  // descending scan so the lowest entering channel wins
  always_comb begin
    first_idx = '0;
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (enter[c]) first_idx = CH_W'(c);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ts            <= '0;
      first_valid_o <= 1'b0;
      first_ch_o    <= '0;
      first_ts_o    <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (first_clr_i) first_valid_o <= 1'b0;
      if ((!first_valid_o || first_clr_i) && (|enter)) begin
        first_valid_o <= 1'b1;
        first_ch_o    <= first_idx;
        first_ts_o    <= ts;
      end
    end
  end
endmodule

// File: tb/tb_i2c_fsm_watchdog.sv
// Directed self-checking bench for i2c_fsm_watchdog (NUM_CH=2, STATE_W=4, CNT_W=16).
module tb_i2c_fsm_watchdog;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  en_i = '0;
  logic [7:0]  state_i = '0;
  logic [1:0]  evt_i = '0;
  logic [15:0] thresh_i = '0;
  logic        idle_exempt_i = 1'b0;
  logic [1:0]  clr_i = '0;
  logic        first_clr_i = 1'b0;
  logic [1:0]  alarm_o;
  logic [3:0]  cause_o;
  logic [31:0] stall_cnt_o;
  logic        irq_o;
  logic        first_valid_o;
  logic [0:0]  first_ch_o;
  logic [15:0] first_ts_o;

  int errors = 0;
  int checks = 0;
  logic [15:0] tb_ts;
  logic [15:0] ts_exp;

  i2c_fsm_watchdog #(.NUM_CH(2), .STATE_W(4), .CNT_W(16), .IDLE_STATE(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .state_i(state_i), .evt_i(evt_i),
    .thresh_i(thresh_i), .idle_exempt_i(idle_exempt_i), .clr_i(clr_i),
    .first_clr_i(first_clr_i), .alarm_o(alarm_o), .cause_o(cause_o),
    .stall_cnt_o(stall_cnt_o), .irq_o(irq_o), .first_valid_o(first_valid_o),
    .first_ch_o(first_ch_o), .first_ts_o(first_ts_o)
  );

  always #5 clk_i = ~clk_i;

  // reference timestamp: counts edges since reset release
  always @(posedge clk_i or posedge rst_i)
    if (rst_i) tb_ts <= '0;
    else       tb_ts <= tb_ts + 16'd1;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (alarm_o !== 2'b00) begin errors++; $display("FAIL reset_alarm got=%b exp=00", alarm_o); end
    checks++; if (cause_o !== 4'b0000) begin errors++; $display("FAIL reset_cause got=%b exp=0000", cause_o); end
    checks++; if (stall_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", stall_cnt_o); end
    checks++; if ({irq_o, first_valid_o, first_ch_o, first_ts_o} !== 19'h0) begin errors++;
      $display("FAIL reset_misc got irq=%b fv=%b fch=%b fts=%h exp all 0", irq_o, first_valid_o, first_ch_o, first_ts_o); end
    step(); step();
    rst_i = 1'b0;
  endtask

  task automatic test_stall();
    logic [3:0] s1;
    s1 = 4'h5;
    en_i = 2'b11; thresh_i = 16'd4; state_i = {s1, 4'h3};
    step();                               // OFF -> TRACK
    for (int i = 0; i < 4; i++) begin     // prime + 3 matches
      s1 = (s1 == 4'h5) ? 4'h6 : 4'h5; state_i = {s1, 4'h3};
      step();
    end
    checks++; if (alarm_o !== 2'b00 || stall_cnt_o[15:0] !== 16'd3) begin errors++;
      $display("FAIL stall_pre got alarm=%b cnt0=%0d exp alarm=00 cnt0=3", alarm_o, stall_cnt_o[15:0]); end
    s1 = (s1 == 4'h5) ? 4'h6 : 4'h5; state_i = {s1, 4'h3};
    ts_exp = tb_ts;
    step();                               // 4th match
    checks++; if (alarm_o !== 2'b01) begin errors++; $display("FAIL stall_alarm got=%b exp=01", alarm_o); end
    checks++; if (cause_o !== 4'b0001) begin errors++; $display("FAIL stall_cause got=%b exp=0001", cause_o); end
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL stall_irq got=%b exp=1", irq_o); end
    checks++; if (first_valid_o !== 1'b1 || first_ch_o !== 1'b0 || first_ts_o !== ts_exp) begin errors++;
      $display("FAIL stall_first got fv=%b ch=%0d ts=%0d exp fv=1 ch=0 ts=%0d", first_valid_o, first_ch_o, first_ts_o, ts_exp); end
    for (int i = 0; i < 10; i++) begin
      s1 = (s1 == 4'h5) ? 4'h6 : 4'h5; state_i = {s1, 4'h3};
      step();
    end
    checks++; if (alarm_o !== 2'b01 || stall_cnt_o !== {16'd0, 16'd4}) begin errors++;
      $display("FAIL stall_hold got alarm=%b cnt=%h exp alarm=01 cnt=00000004", alarm_o, stall_cnt_o); end
  endtask

  task automatic test_idle();
    logic bad;
    bad = 1'b0;
    en_i = 2'b00; first_clr_i = 1'b1; step(); first_clr_i = 1'b0;
    en_i = 2'b01; idle_exempt_i = 1'b1; thresh_i = 16'd4; state_i = 8'h00;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (alarm_o !== 2'b00 || stall_cnt_o[15:0] !== 16'd0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL idle_exempt got=%b exp=0 (alarm or count seen)", bad); end
    idle_exempt_i = 1'b0;
    step(); step(); step();
    checks++; if (alarm_o !== 2'b00 || stall_cnt_o[15:0] !== 16'd3) begin errors++;
      $display("FAIL idle_pre got alarm=%b cnt0=%0d exp alarm=00 cnt0=3", alarm_o, stall_cnt_o[15:0]); end
    step();
    checks++; if (alarm_o !== 2'b01 || cause_o !== 4'b0001 || stall_cnt_o[15:0] !== 16'd4) begin errors++;
      $display("FAIL idle_alarm got alarm=%b cause=%b cnt0=%0d exp 01 0001 4", alarm_o, cause_o, stall_cnt_o[15:0]); end
  endtask

  task automatic test_event();
    en_i = 2'b00; first_clr_i = 1'b1; step(); first_clr_i = 1'b0;
    en_i = 2'b11; thresh_i = 16'd0; state_i = 8'h21;
    step(); step();
    evt_i = 2'b10; ts_exp = tb_ts;
    step();
    evt_i = 2'b00;
    checks++; if (alarm_o !== 2'b10 || cause_o !== 4'b1000) begin errors++;
      $display("FAIL event_alarm got alarm=%b cause=%b exp 10 1000", alarm_o, cause_o); end
    checks++; if (first_valid_o !== 1'b1 || first_ch_o !== 1'b1 || first_ts_o !== ts_exp) begin errors++;
      $display("FAIL event_first got fv=%b ch=%0d ts=%0d exp fv=1 ch=1 ts=%0d", first_valid_o, first_ch_o, first_ts_o, ts_exp); end
    step();
    checks++; if (alarm_o !== 2'b10) begin errors++; $display("FAIL event_sticky got=%b exp=10", alarm_o); end
  endtask

  task automatic test_clear_race();
    clr_i = 2'b10; evt_i = 2'b10;
    step();
    clr_i = 2'b00; evt_i = 2'b00;
    checks++; if (alarm_o !== 2'b10 || cause_o[3:2] !== 2'b10) begin errors++;
      $display("FAIL race_hold got alarm=%b cause=%b exp alarm=10 cause[3:2]=10", alarm_o, cause_o); end
    clr_i = 2'b10;
    step();
    clr_i = 2'b00;
    checks++; if (alarm_o !== 2'b00 || cause_o !== 4'b0000) begin errors++;
      $display("FAIL clear got alarm=%b cause=%b exp 00 0000", alarm_o, cause_o); end
    step();
    checks++; if (stall_cnt_o[31:16] !== 16'd0) begin errors++; $display("FAIL clear_prime got cnt1=%0d exp=0", stall_cnt_o[31:16]); end
    step();
    checks++; if (stall_cnt_o[31:16] !== 16'd1) begin errors++; $display("FAIL clear_resume got cnt1=%0d exp=1", stall_cnt_o[31:16]); end
  endtask

  task automatic test_first_record();
    en_i = 2'b00; first_clr_i = 1'b1; step(); first_clr_i = 1'b0;
    checks++; if (first_valid_o !== 1'b0) begin errors++; $display("FAIL first_clr got=%b exp=0", first_valid_o); end
    en_i = 2'b11; thresh_i = 16'd3; state_i = 8'h77;
    step(); step(); step(); step();
    ts_exp = tb_ts;
    step();
    checks++; if (alarm_o !== 2'b11 || cause_o !== 4'b0101) begin errors++;
      $display("FAIL simul_alarm got alarm=%b cause=%b exp 11 0101", alarm_o, cause_o); end
    checks++; if (first_ch_o !== 1'b0 || first_ts_o !== ts_exp) begin errors++;
      $display("FAIL simul_first got ch=%0d ts=%0d exp ch=0 ts=%0d", first_ch_o, first_ts_o, ts_exp); end
    first_clr_i = 1'b1; clr_i = 2'b10;
    step();
    clr_i = 2'b00;
    checks++; if (first_valid_o !== 1'b0 || alarm_o !== 2'b01) begin errors++;
      $display("FAIL recl got fv=%b alarm=%b exp fv=0 alarm=01", first_valid_o, alarm_o); end
    evt_i = 2'b10; ts_exp = tb_ts;        // first_clr still high: entry must win
    step();
    evt_i = 2'b00; first_clr_i = 1'b0;
    checks++; if (first_valid_o !== 1'b1 || first_ch_o !== 1'b1 || first_ts_o !== ts_exp) begin errors++;
      $display("FAIL recap got fv=%b ch=%0d ts=%0d exp fv=1 ch=1 ts=%0d", first_valid_o, first_ch_o, first_ts_o, ts_exp); end
    checks++; if (cause_o !== 4'b1001) begin errors++; $display("FAIL recap_cause got=%b exp=1001", cause_o); end
  endtask

  task automatic test_disable();
    en_i = 2'b10;
    step();
    checks++; if (alarm_o !== 2'b10 || cause_o !== 4'b1000 || stall_cnt_o[15:0] !== 16'd0) begin errors++;
      $display("FAIL disable got alarm=%b cause=%b cnt0=%0d exp 10 1000 0", alarm_o, cause_o, stall_cnt_o[15:0]); end
  endtask

  task automatic test_reset_mid();
    en_i = 2'b00; step();
    en_i = 2'b11; thresh_i = 16'd100; state_i = 8'h55;
    step(); step();
    evt_i = 2'b10; step(); evt_i = 2'b00;
    step(); step();
    checks++; if (stall_cnt_o[15:0] !== 16'd3 || alarm_o !== 2'b10) begin errors++;
      $display("FAIL mid_pre got cnt0=%0d alarm=%b exp 3 10", stall_cnt_o[15:0], alarm_o); end
    #2 rst_i = 1'b1;
    #1;
    checks++; if ({alarm_o, cause_o, irq_o, first_valid_o, first_ch_o} !== 9'h0 || stall_cnt_o !== 32'h0 || first_ts_o !== 16'h0) begin errors++;
      $display("FAIL mid_reset got alarm=%b cause=%b irq=%b fv=%b cnt=%h exp all 0", alarm_o, cause_o, irq_o, first_valid_o, stall_cnt_o); end
    @(negedge clk_i) rst_i = 1'b0;
    step();
    checks++; if (alarm_o !== 2'b00 || stall_cnt_o !== 32'h0) begin errors++;
      $display("FAIL post_off got alarm=%b cnt=%h exp 00 0", alarm_o, stall_cnt_o); end
    step(); step();
    checks++; if (stall_cnt_o[15:0] !== 16'd1) begin errors++; $display("FAIL post_count got cnt0=%0d exp=1", stall_cnt_o[15:0]); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_idle();
    test_event();
    test_clear_race();
    test_first_record();
    test_disable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
